// File: rtl/dsp48a1_mac_ctrl.sv
// dsp48a1_mac_ctrl: sequences a DSP48A1 slice as a signed dot-product MAC.
module dsp48a1_mac_ctrl #(
  parameter int WIDTH = 18,
  parameter int LEN_W = 8,
  parameter int M_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] dsp_a_o,
  output logic [WIDTH-1:0] dsp_b_o,
  output logic [7:0]       dsp_opmode_o,
  output logic             dsp_cep_o,
  input  logic [47:0]      dsp_p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [47:0]      result_o
);
  localparam int DW = $clog2(M_LAT + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(M_LAT);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;
  state_e state_q;
  logic [LEN_W-1:0] remain_q;
  logic [DW-1:0] drain_q;
  logic first_q, hs;
  logic [M_LAT-1:0] vld_q, fst_q, vld_d, fst_d;
  logic [WIDTH-1:0] dsp_a_q, dsp_b_q;
  logic [7:0] opmode_q;
  logic [47:0] result_q;
  // Tag pipeline: index 0 is the newest tag, index M_LAT-1 drives the slice.
  always_comb begin
    hs = (state_q == LOAD) && in_valid_i;
    vld_d = {vld_q[M_LAT-2:0], hs};
    fst_d = {fst_q[M_LAT-2:0], hs && first_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      remain_q <= '0;
      drain_q <= '0;
      first_q <= 1'b0;
      vld_q <= '0;
      fst_q <= '0;
      dsp_a_q <= '0;
      dsp_b_q <= '0;
      opmode_q <= 8'h00;
      result_q <= '0;
    end else begin
      vld_q <= vld_d;
      fst_q <= fst_d;
      if (vld_d[M_LAT-1]) opmode_q <= fst_d[M_LAT-1] ? 8'h01 : 8'h09;
      if (hs) begin
        dsp_a_q <= a_i;
        dsp_b_q <= b_i;
      end
      case (state_q)
        IDLE: if (start_i) begin
          remain_q <= len_i;
          first_q <= 1'b1;
          if (len_i == '0) begin
            result_q <= '0;
            state_q <= DONE;
          end else state_q <= LOAD;
        end
        LOAD: if (hs) begin
          remain_q <= remain_q - LEN_W'(1);
          first_q <= 1'b0;
          if (remain_q == LEN_W'(1)) begin
            drain_q <= '0;
            state_q <= DRAIN;
          end
        end
        // P holds the last pair once its tag has left the pipeline and P has clocked.
        DRAIN: begin
          drain_q <= drain_q + DW'(1);
          if (drain_q == DRAIN_LAST) begin
            result_q <= dsp_p_i;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready_o = state_q == LOAD;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign dsp_a_o = dsp_a_q;
  assign dsp_b_o = dsp_b_q;
  assign dsp_opmode_o = opmode_q;
  assign dsp_cep_o = vld_q[M_LAT-1];
  assign result_o = result_q;
endmodule
